// File: rtl/idct_pkg.sv
// Shared IDCT definitions: coefficient widths, block size, zigzag table and
// the block-loader FSM state type.
package idct_pkg;

  localparam int unsigned WIN   = 12;  // IDCT input coefficient width
  localparam int unsigned WOUT  = 9;   // IDCT output sample width
  localparam int unsigned NCOEF = 64;  // fixed 8x8 block
  localparam int unsigned IDX_W = 6;   // index into a 64-entry block

  typedef logic signed [WIN-1:0] coef_t;

  // Stream index k -> natural raster position (row*8+col).
  localparam logic [IDX_W-1:0] ZZ [NCOEF] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic {
    FILL = 1'b0,  // accepting beats
    WAIT = 1'b1   // block complete, output register still occupied
  } loader_state_e;

endpackage

// File: rtl/idct_block_loader_if.sv
// Coefficient stream in, flat 8x8 block out.
//   in_data/in_valid/in_last/in_ready : zigzag coefficient stream
//   x/out_valid/out_ready             : block presented to the IDCT core
//   err_len                           : block closed at 64 beats without in_last
// master = stream source / block sink, slave = loader.
interface idct_block_loader_if;
  import idct_pkg::*;

  coef_t                    in_data;
  logic                     in_valid;
  logic                     in_last;
  logic                     in_ready;
  logic [NCOEF*WIN-1:0]     x;
  logic                     out_valid;
  logic                     out_ready;
  logic                     err_len;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, x, out_valid, err_len
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, x, out_valid, err_len
  );
endinterface

// File: rtl/idct_zigzag_map.sv
// Combinational stream-index -> natural-position map.
//   i_idx   : stream position of the beat (0..63)
//   o_pos_c : raster position to write (row*8+col)
module idct_zigzag_map
  import idct_pkg::*;
#(
  parameter bit ZIGZAG = 1'b1
) (
  input  logic [IDX_W-1:0] i_idx,
  output logic [IDX_W-1:0] o_pos_c
);

  if (ZIGZAG) begin : g_zz
    assign o_pos_c = ZZ[i_idx];
  end else begin : g_nat
    assign o_pos_c = i_idx;
  end

endmodule

// File: rtl/idct_block_loader.sv
// Collects a zigzag coefficient stream into a natural-order 8x8 block and
// hands it to the IDCT core under an out_valid/out_ready handshake.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : stream input, block output, length-error pulse
module idct_block_loader
  import idct_pkg::*;
#(
  parameter bit ZIGZAG = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  idct_block_loader_if.slave bus
);

  loader_state_e         r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [NCOEF*WIN-1:0]  r_fill;
  logic [NCOEF*WIN-1:0]  r_x;
  logic                  r_out_valid;
  logic                  r_in_ready;
  logic                  r_err_len;

  logic [IDX_W-1:0]      w_pos;
  logic [NCOEF*WIN-1:0]  w_fill_merged;
  logic                  w_accept;
  logic                  w_last_idx;
  logic                  w_final;
  logic                  w_slot_free;

  idct_zigzag_map #(.ZIGZAG(ZIGZAG)) u_map (
    .i_idx   (r_idx),
    .o_pos_c (w_pos)
  );

  assign w_accept    = bus.in_valid && r_in_ready;
  assign w_last_idx  = (r_idx == IDX_W'(NCOEF - 1));
  assign w_final     = w_accept && (bus.in_last || w_last_idx);
  assign w_slot_free = !r_out_valid || bus.out_ready;

  // Fill buffer with the current beat dropped into its raster slot.
  always_comb begin
    w_fill_merged = r_fill;
    w_fill_merged[int'(w_pos) * WIN +: WIN] = bus.in_data;
  end

  // Loader FSM; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FILL;
      r_idx       <= '0;
      r_fill      <= '0;
      r_x         <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_err_len   <= 1'b0;
    end else begin
      r_err_len <= 1'b0;
      // Downstream took the block; a commit below overrides this.
      if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;

      case (r_state)
        FILL: begin
          if (w_accept) begin
            if (w_final) begin
              r_err_len <= w_last_idx && !bus.in_last;
              r_idx     <= '0;
              if (w_slot_free) begin
                r_x         <= w_fill_merged;
                r_fill      <= '0;
                r_out_valid <= 1'b1;
              end else begin
                r_fill     <= w_fill_merged;
                r_state    <= WAIT;
                r_in_ready <= 1'b0;
              end
            end else begin
              r_fill <= w_fill_merged;
              r_idx  <= r_idx + 1'b1;
            end
          end
        end
        WAIT: begin
          if (w_slot_free) begin
            r_x         <= r_fill;
            r_fill      <= '0;
            r_out_valid <= 1'b1;
            r_state     <= FILL;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state    <= FILL;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.x         = r_x;
  assign bus.out_valid = r_out_valid;
  assign bus.in_ready  = r_in_ready;
  assign bus.err_len   = r_err_len;

endmodule

// File: doc/idct_block_loader.md
Name: idct_block_loader

Overview:
- Upstream neighbour of the 8x8 IDCT core.
- Accepts dequantised DCT coefficients as a valid/ready stream, one per beat, in zigzag order.
- Scatters each coefficient to its natural raster position and zero-fills after an early end-of-block.
- Presents the complete 64-coefficient block as the flat bus the IDCT x input expects, held stable under an out_valid/out_ready handshake.

Parameters:
- WIN, 12, coefficient width (signed, two's complement); equals IDCT input width.
- NCOEF, 64, coefficients per block (fixed 8x8; not intended to be overridden).
- ZIGZAG, 1, 1 = stream index k maps to natural position ZZ[k]; 0 = natural order (position = k).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  WIN  signed coefficient.
- in_valid  in  1  in_data valid.
- in_last  in  1  end-of-block marker on this beat; remaining positions are zero.
- in_ready  out  1  loader accepts a beat this cycle.
- x  out  NCOEF*WIN  block; position p (row*8+col) at bits [p*WIN +: WIN]; position 0 at LSB.
- out_valid  out  1  x holds a complete block.
- out_ready  in  1  downstream takes x this cycle.
- err_len  out  1  one-cycle pulse: block closed at 64th coefficient without in_last.

Behaviour:
- Storage: fill buffer (NCOEF x WIN) plus output register x; both zero after reset.
- Counter idx (0..63): stream position of the next beat.
- Accept = in_valid && in_ready. On accept, fill[map(idx)] <= in_data and idx increments.
- map(k) = ZZ[k] if ZIGZAG, else k.
- ZZ = 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
- Final beat = accepted beat with in_last=1, or with idx==63.
- slot_free = !out_valid || out_ready.
- FSM states:
  - FILL: in_ready=1.
  - WAIT: in_ready=0; block complete but output register occupied.
- Commit (one edge):
  - x <= fill with the final beat merged in.
  - fill <= all zero; idx <= 0; out_valid <= 1.
- FILL + final beat + slot_free: commit on the same edge, stay in FILL. Back-to-back blocks need no bubble.
- FILL + final beat + !slot_free: write the beat into fill and go to WAIT.
- WAIT + slot_free: commit, go to FILL.
- out_valid && out_ready with no commit on that edge: out_valid <= 0; x keeps its value.
- x changes only on commit; stable while out_valid=1 and out_ready=0.
- Early EOB (in_last at idx<63): unwritten positions stay zero from the prior clear. A block of a single beat (DC only) is legal.
- err_len: pulses on the edge after a final beat at idx==63 with in_last=0. The block still commits normally.
- in_last at idx==63 is normal; no error.
- No arithmetic: data is copied bit-exact, no width change.
- Latency: final beat accepted at edge N -> out_valid=1 after edge N (if slot_free).
- Reset (any cycle, including mid-block or in WAIT):
  - idx=0, state FILL, fill and x zero.
  - out_valid=0, err_len=0.
  - in_ready=1 in the first cycle after reset deasserts.
  - Partial block is discarded.

Decomposition:
- Shared package idct_pkg:
  - WIN/WOUT constants, NCOEF=64.
  - coef_t (signed [WIN-1:0]).
  - ZZ table as a localparam array, reused by any future zigzag encoder or reorder block.
  - FSM state enum {FILL, WAIT}.
- One sub-module is natural: idct_zigzag_map.
  - Combinational, 6-bit stream index -> 6-bit natural position.
  - Parameter ZIGZAG.
  - Verified standalone against the ZZ table.

Test Plan:
- Full block, zigzag: stream ZZ-ordered coefficients of the standard test block (natural pos0=-240, pos1=8, pos8=28, pos63=-8), out_ready=1, in_last on beat 63 -> out_valid one cycle after the last accept; x[0 +: 12]=-240, x[12 +: 12]=8, x[96 +: 12]=28, x[756 +: 12]=-8; err_len=0.
- Early EOB: beats 50, -3, 7 with in_last on the third -> pos0=50, pos1=-3, pos8=7, all other 61 positions 0. Then a second block of 64 beats of 1 -> x all 1, no residue from the first block.
- Backpressure: out_ready=0 while a second block completes -> state WAIT, in_ready=0, x unchanged. Raise out_ready -> commit on the next edge, in_ready=1 on the following cycle, no beat lost or duplicated.
- Back-to-back: in_valid continuously high, out_ready=1, three 64-beat blocks -> out_valid pulses every 64 cycles, in_ready never deasserts.
- Length error: 64 beats with in_last=0 throughout -> err_len high exactly one cycle, block committed intact. The next beat starts a new block at idx 0.
- Reset mid-block: rst high for one cycle after 20 beats -> out_valid=0, x=0. A subsequent full block matches expected values with no stale coefficients.
